// File: rtl/prog_fetch.sv
// prog_fetch: program buffer and instruction sequencer.
// Loads PROG_LEN 64-bit words from the generator, then replays them in order
// ITER times as a valid/ready stream toward the decoder, with branch redirect.
// Optional build macro: PROG_FETCH_PERF_EN adds the 32-bit stall_cnt_o output.
module prog_fetch #(
  parameter int unsigned PROG_LEN = 256,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ITER     = 2048,
  parameter int unsigned ITER_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_v_i,
  output logic              in_ready_o,
  input  logic [63:0]       in_data_i,
  output logic              instr_v_o,
  input  logic              instr_ready_i,
  output logic [63:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              branch_v_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  output logic              done_o
`ifdef PROG_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int unsigned DATA_W = 64;
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(PROG_LEN - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_n;

  logic [DATA_W-1:0]   mem [PROG_LEN];
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   fpc;
  logic [ITER_W-1:0]   iter_cnt;

  logic                in_hs;
  logic                out_hs;
  logic                wrap_hs;
  logic                finish;
  logic                branch_take;
  logic                out_adv;
  logic                load_start;
  logic                run_start;

  // Next-state and per-cycle control decode
  always_comb begin
    state_n     = state;
    in_hs       = 1'b0;
    out_hs      = 1'b0;
    wrap_hs     = 1'b0;
    finish      = 1'b0;
    branch_take = 1'b0;
    out_adv     = 1'b0;
    load_start  = 1'b0;
    run_start   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        in_hs = in_v_i & in_ready_o;
        if (in_hs && (wptr == LAST_PC)) begin
          state_n   = RUN;
          run_start = 1'b1;
        end
      end
      RUN: begin
        out_hs      = instr_v_o & instr_ready_i;
        wrap_hs     = out_hs && (pc_o == LAST_PC);
        finish      = wrap_hs && (iter_cnt == LAST_ITER);
        // Completion takes priority over a coincident redirect
        branch_take = branch_v_i && !finish;
        out_adv     = !instr_v_o || instr_ready_i;
        if (finish) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Program buffer write port; contents survive DONE and reset
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[wptr] <= in_data_i;
    end
  end

  // Load write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (load_start) begin
      wptr <= '0;
    end else if (in_hs) begin
      wptr <= wptr + ADDR_W'(1);
    end
  end

  // Registered handshake/status outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      in_ready_o <= (state_n == LOAD);
      done_o     <= (state_n == DONE);
    end
  end

  // Fetch pc, iteration count and the output register (1-cycle buffer read)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc       <= '0;
      iter_cnt  <= '0;
      instr_v_o <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
    end else if (run_start) begin
      fpc       <= '0;
      iter_cnt  <= '0;
      instr_v_o <= 1'b0;
    end else if (state == RUN) begin
      if (wrap_hs) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
      end
      if (finish) begin
        instr_v_o <= 1'b0;
      end else if (branch_take) begin
        // Withdraw the presented word; target is read next cycle
        instr_v_o <= 1'b0;
        fpc       <= branch_pc_i;
      end else if (out_adv) begin
        instr_o   <= mem[fpc];
        pc_o      <= fpc;
        instr_v_o <= 1'b1;
        fpc       <= fpc + ADDR_W'(1);
      end
    end else begin
      instr_v_o <= 1'b0;
    end
  end

`ifdef PROG_FETCH_PERF_EN
  logic bubble;

  // Marks the flush cycle that follows an honoured branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble <= 1'b0;
    end else begin
      bubble <= branch_take;
    end
  end

  // Saturating count of back-pressure stalls and branch bubbles in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (load_start) begin
      stall_cnt_o <= '0;
    end else if ((state == RUN) && ((instr_v_o && !instr_ready_i) || bubble) &&
                 (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch with PROG_LEN=4, ITER=2.
module tb_prog_fetch;

  localparam int unsigned PROG_LEN = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned ITER     = 2;
  localparam int unsigned ITER_W   = 2;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              in_v_i;
  logic              in_ready_o;
  logic [63:0]       in_data_i;
  logic              instr_v_o;
  logic              instr_ready_i;
  logic [63:0]       instr_o;
  logic [ADDR_W-1:0] pc_o;
  logic              branch_v_i;
  logic [ADDR_W-1:0] branch_pc_i;
  logic              done_o;
`ifdef PROG_FETCH_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  typedef struct {
    logic [63:0]       data;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] BASE_A = 64'hA000_0000_0000_0000;
  localparam logic [63:0] BASE_X = 64'h1111_0000_0000_0000;
  localparam logic [63:0] BASE_Y = 64'h2222_0000_0000_0000;
  localparam logic [63:0] BASE_Z = 64'h3333_0000_0000_0000;

  prog_fetch #(
    .PROG_LEN(PROG_LEN),
    .ADDR_W  (ADDR_W),
    .ITER    (ITER),
    .ITER_W  (ITER_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .in_v_i       (in_v_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .instr_v_o    (instr_v_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .branch_v_i   (branch_v_i),
    .branch_pc_i  (branch_pc_i),
    .done_o       (done_o)
`ifdef PROG_FETCH_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input int p);
    exp_t e;
    e.data = d;
    e.pc   = ADDR_W'(p);
    exp_q.push_back(e);
  endtask

  // Pulse start in IDLE, then present words base|1..base|4 following pat
  task automatic load_prog(input logic [63:0] base, input logic [7:0] pat, input int n);
    int k;
    k = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_v_i    = pat[i];
      in_data_i = pat[i] ? (base | 64'(k + 1)) : 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      if (pat[i]) k++;
    end
    in_v_i = 1'b0;
  endtask

  // Monitor: every decoder handshake pops and checks the next expected word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_v_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got pc=%0d instr=%h exp=none", pc_o, instr_o);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", instr_o, e.data);
          chk("sb_pc", 64'(pc_o), 64'(e.pc));
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    in_v_i        = 1'b0;
    in_data_i     = '0;
    instr_ready_i = 1'b1;
    branch_v_i    = 1'b0;
    branch_pc_i   = '0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_instr_v", 64'(instr_v_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_instr", instr_o, 64'd0);
    chk("rst_pc", 64'(pc_o), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Gapped load, then two full passes with no back-pressure
    for (int it = 0; it < 2; it++)
      for (int p = 0; p < 4; p++) push(BASE_A | 64'(p + 1), p);
    load_prog(BASE_A, 8'b0010_1101, 6);
    @(negedge clk);
    chk("a_first_bubble", 64'(instr_v_o), 64'd0);
    chk("a_load_ready_off", 64'(in_ready_o), 64'd0);
    step();
    @(negedge clk);
    chk("a_first_valid", 64'(instr_v_o), 64'd1);
    chk("a_first_pc", 64'(pc_o), 64'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      @(negedge clk);
      chk("a_no_bubble", 64'(instr_v_o), 64'd1);
    end
    step();
    @(negedge clk);
    chk("a_done_pulse", 64'(done_o), 64'd1);
    chk("a_done_no_valid", 64'(instr_v_o), 64'd0);
    step();
    @(negedge clk);
    chk("a_done_single", 64'(done_o), 64'd0);
    chk("a_idle_ready", 64'(in_ready_o), 64'd0);

    // Stall at pc 2, branch on the wrap handshake, start ignored in RUN
    push(BASE_X | 64'd1, 0);
    push(BASE_X | 64'd2, 1);
    push(BASE_X | 64'd3, 2);
    push(BASE_X | 64'd4, 3);
    push(BASE_X | 64'd2, 1);
    push(BASE_X | 64'd3, 2);
    push(BASE_X | 64'd4, 3);
    load_prog(BASE_X, 8'h0F, 4);
    step();
    step();
    step();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_stall_valid", 64'(instr_v_o), 64'd1);
      chk("b_stall_pc", 64'(pc_o), 64'd2);
      chk("b_stall_instr", instr_o, BASE_X | 64'd3);
      step();
    end
    instr_ready_i = 1'b1;
`ifdef PROG_FETCH_PERF_EN
    @(negedge clk);
    chk("b_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    step();
    branch_v_i  = 1'b1;
    branch_pc_i = 2'd1;
    @(negedge clk);
    chk("b_branch_src_pc", 64'(pc_o), 64'd3);
    step();
    branch_v_i = 1'b0;
    @(negedge clk);
    chk("b_branch_bubble", 64'(instr_v_o), 64'd0);
    chk("b_no_done_yet", 64'(done_o), 64'd0);
    step();
    @(negedge clk);
    chk("b_target_valid", 64'(instr_v_o), 64'd1);
    chk("b_target_pc", 64'(pc_o), 64'd1);
`ifdef PROG_FETCH_PERF_EN
    chk("b_stall_cnt_bubble", 64'(stall_cnt), 64'd6);
`endif
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("b_start_ignored", 64'(in_ready_o), 64'd0);
    chk("b_pc3_valid", 64'(pc_o), 64'd3);
    chk("b_no_early_done", 64'(done_o), 64'd0);
    step();
    @(negedge clk);
    chk("b_done_pulse", 64'(done_o), 64'd1);
    step();
    @(negedge clk);
    chk("b_done_single", 64'(done_o), 64'd0);
    chk("b_idle_ready", 64'(in_ready_o), 64'd0);

    // Reset mid-run, then reload a different program
    push(BASE_Y | 64'd1, 0);
    push(BASE_Y | 64'd2, 1);
    load_prog(BASE_Y, 8'h0F, 4);
    step();
    step();
    step();
    instr_ready_i = 1'b0;
    @(negedge clk);
    chk("c_pre_rst_pc", 64'(pc_o), 64'd2);
    chk("c_pre_rst_instr", instr_o, BASE_Y | 64'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("c_rst_valid", 64'(instr_v_o), 64'd0);
    chk("c_rst_pc", 64'(pc_o), 64'd0);
    chk("c_rst_instr", instr_o, 64'd0);
    step();
    rst           = 1'b0;
    instr_ready_i = 1'b1;
    for (int it = 0; it < 2; it++)
      for (int p = 0; p < 4; p++) push(BASE_Z | 64'(p + 1), p);
    load_prog(BASE_Z, 8'h0F, 4);
    step();
    @(negedge clk);
    chk("c_reload_pc", 64'(pc_o), 64'd0);
    chk("c_reload_instr", instr_o, BASE_Z | 64'd1);
    for (int i = 0; i < 7; i++) step();
    step();
    @(negedge clk);
    chk("c_done_pulse", 64'(done_o), 64'd1);
    step();
    step();
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
